// File: rtl/pfc_router_pkg.sv
// Shared types and constants for the PFC bank router: state encoding,
// bus widths, captured-command payload and bank-index width helper.
package pfc_router_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned BANK_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [BANK_SEL_W-1:0] bank;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
  } cmd_t;

  // Bits needed to index n banks; a single bank still gets one bit.
  function automatic int unsigned bank_idx_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/pfc_bank_router_if.sv
// Command/response handshake plus the shared bank-side bus of the router.
interface pfc_bank_router_if
  import pfc_router_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_write;
  logic [BANK_SEL_W-1:0]         cmd_bank;
  logic [ADDR_W-1:0]             cmd_addr;
  logic [DATA_W-1:0]             cmd_wdata;
  logic                          resp_valid;
  logic [DATA_W-1:0]             resp_data;
  logic                          resp_err;
  logic [NUM_BANKS-1:0]          bank_write;
  logic [ADDR_W-1:0]             bank_addr;
  logic [DATA_W-1:0]             bank_wdata;
  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_bank, cmd_addr, cmd_wdata, bank_rdata,
    input  cmd_ready, resp_valid, resp_data, resp_err,
           bank_write, bank_addr, bank_wdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_bank, cmd_addr, cmd_wdata, bank_rdata,
    output cmd_ready, resp_valid, resp_data, resp_err,
           bank_write, bank_addr, bank_wdata
  );
endinterface

// File: rtl/pfc_reset_sync.sv
// Flop-chain synchroniser bringing the asynchronous CPU reset request
// into the core clock domain.
module pfc_reset_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock_core_sig,
  input  logic qsys_reset_n_sig,
  input  logic resetreq_in,
  output logic resetreq_out
);
  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clock_core_sig or negedge qsys_reset_n_sig) begin
    if (!qsys_reset_n_sig) chain_q <= '0;
    else                   chain_q <= {chain_q[SYNC_STAGES-2:0], resetreq_in};
  end

  assign resetreq_out = chain_q[SYNC_STAGES-1];
endmodule

// File: rtl/pfc_bank_router.sv
// Routes single register commands to one of NUM_BANKS PFC banks with a
// fixed IDLE/ISSUE/RESP sequence and flags out-of-range bank indices.
module pfc_bank_router
  import pfc_router_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clock_core_sig,
  input  logic               qsys_reset_n_sig,
  pfc_bank_router_if.slave   bus,
  input  logic               err_clear,
  output logic               err_sticky,
  input  logic               resetreq_in,
  output logic               resetreq_out
);
  localparam int unsigned BANK_W = bank_idx_w(NUM_BANKS);

  state_e               state_q, state_d;
  logic                 ready_q, ready_d;
  cmd_t                 cmd_q, cmd_d;
  logic [NUM_BANKS-1:0] wr_q, wr_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [DATA_W-1:0]    resp_data_q, resp_data_d;
  logic                 sticky_q, sticky_d;

  logic                 accept;
  logic                 in_range;
  logic [BANK_W-1:0]    rd_idx;
  logic [DATA_W-1:0]    rd_slice;

  assign accept   = bus.cmd_valid && ready_q;
  assign in_range = (32'(cmd_q.bank) < NUM_BANKS);
  assign rd_idx   = cmd_q.bank[BANK_W-1:0];

  // Read-data mux over the concatenated bank readdata bus.
  always_comb begin
    rd_slice = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (rd_idx == BANK_W'(k)) rd_slice = bus.bank_rdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    wr_d         = '0;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    sticky_d     = sticky_q & ~err_clear;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d.write = bus.cmd_write;
          cmd_d.bank  = bus.cmd_bank;
          cmd_d.addr  = bus.cmd_addr;
          cmd_d.wdata = bus.cmd_wdata;
          // Strobe is registered here so it is live for the whole ISSUE cycle.
          for (int k = 0; k < NUM_BANKS; k++) begin
            wr_d[k] = bus.cmd_write && (bus.cmd_bank == BANK_SEL_W'(k));
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = !in_range;
        resp_data_d  = (in_range && !cmd_q.write) ? rd_slice : '0;
        if (!in_range) sticky_d = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock_core_sig or negedge qsys_reset_n_sig) begin
    if (!qsys_reset_n_sig) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      cmd_q        <= '0;
      wr_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      cmd_q        <= cmd_d;
      wr_q         <= wr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      sticky_q     <= sticky_d;
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.bank_write = wr_q;
  assign bus.bank_addr  = cmd_q.addr;
  assign bus.bank_wdata = cmd_q.wdata;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;
  assign err_sticky     = sticky_q;

  pfc_reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_reset_sync (
    .clock_core_sig   (clock_core_sig),
    .qsys_reset_n_sig (qsys_reset_n_sig),
    .resetreq_in      (resetreq_in),
    .resetreq_out     (resetreq_out)
  );
endmodule

// File: tb/tb_pfc_bank_router.sv
// Directed bench: a 4-bank/3-stage router and a 1-bank/2-stage router
// driven from one linear sequence with hand-computed expectations.
module tb_pfc_bank_router;
  import pfc_router_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic err_clear0, err_clear1, sticky0, sticky1;
  logic rr_in0, rr_in1, rr_out0, rr_out1;
  int   checks = 0;
  int   errors = 0;

  pfc_bank_router_if #(.NUM_BANKS(4)) b0 ();
  pfc_bank_router_if #(.NUM_BANKS(1)) b1 ();

  pfc_bank_router #(.NUM_BANKS(4), .SYNC_STAGES(3)) dut0 (
    .clock_core_sig   (clk),
    .qsys_reset_n_sig (rst_n),
    .bus              (b0.slave),
    .err_clear        (err_clear0),
    .err_sticky       (sticky0),
    .resetreq_in      (rr_in0),
    .resetreq_out     (rr_out0)
  );

  pfc_bank_router #(.NUM_BANKS(1), .SYNC_STAGES(2)) dut1 (
    .clock_core_sig   (clk),
    .qsys_reset_n_sig (rst_n),
    .bus              (b1.slave),
    .err_clear        (err_clear1),
    .err_sticky       (sticky1),
    .resetreq_in      (rr_in1),
    .resetreq_out     (rr_out1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd0(input logic wr, input logic [3:0] bank, input logic [1:0] addr,
                      input logic [31:0] data);
    b0.cmd_valid = 1'b1;
    b0.cmd_write = wr;
    b0.cmd_bank  = bank;
    b0.cmd_addr  = addr;
    b0.cmd_wdata = data;
  endtask

  task automatic cmd1(input logic wr, input logic [3:0] bank, input logic [31:0] data);
    b1.cmd_valid = 1'b1;
    b1.cmd_write = wr;
    b1.cmd_bank  = bank;
    b1.cmd_addr  = 2'd3;
    b1.cmd_wdata = data;
  endtask

  initial begin
    err_clear0 = 1'b0; err_clear1 = 1'b0; rr_in0 = 1'b0; rr_in1 = 1'b0;
    b0.bank_rdata = {32'h12345678, 32'hAAAA0002, 32'h11110001, 32'h0000C0DE};
    b1.bank_rdata = 32'h0BADF00D;
    b1.cmd_valid = 1'b0; b1.cmd_write = 1'b0; b1.cmd_bank = 4'd0;
    b1.cmd_addr = 2'd0; b1.cmd_wdata = 32'd0;
    cmd0(1'b1, 4'd2, 2'd1, 32'hFFFF0000);   // must not be taken while in reset

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(b0.cmd_ready), 32'd1);
    chk("rst_bank_write", 32'(b0.bank_write), 32'd0);
    chk("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
    chk("rst_bank_wdata", b0.bank_wdata, 32'd0);
    chk("rst_sticky", 32'(sticky0), 32'd0);
    chk("rst_rr_out", 32'(rr_out0), 32'd0);
    b0.cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Write bank 2
    cmd0(1'b1, 4'd2, 2'd1, 32'hDEADBEEF);
    tick();
    b0.cmd_valid = 1'b0;
    chk("wr_strobe", 32'(b0.bank_write), 32'h4);
    chk("wr_wdata", b0.bank_wdata, 32'hDEADBEEF);
    chk("wr_addr", 32'(b0.bank_addr), 32'd1);
    chk("wr_ready_issue", 32'(b0.cmd_ready), 32'd0);
    chk("wr_no_resp_yet", 32'(b0.resp_valid), 32'd0);
    tick();
    chk("wr_strobe_off", 32'(b0.bank_write), 32'd0);
    chk("wr_resp_valid", 32'(b0.resp_valid), 32'd1);
    chk("wr_resp_data", b0.resp_data, 32'd0);
    chk("wr_resp_err", 32'(b0.resp_err), 32'd0);
    chk("wr_ready_resp", 32'(b0.cmd_ready), 32'd0);
    tick();
    chk("wr_resp_gone", 32'(b0.resp_valid), 32'd0);
    chk("wr_ready_idle", 32'(b0.cmd_ready), 32'd1);
    chk("wr_wdata_held", b0.bank_wdata, 32'hDEADBEEF);

    // Read bank 3
    cmd0(1'b0, 4'd3, 2'd2, 32'h0);
    tick();
    b0.cmd_valid = 1'b0;
    chk("rd_no_strobe", 32'(b0.bank_write), 32'd0);
    chk("rd_addr", 32'(b0.bank_addr), 32'd2);
    tick();
    chk("rd_resp_valid", 32'(b0.resp_valid), 32'd1);
    chk("rd_resp_data", b0.resp_data, 32'h12345678);
    chk("rd_resp_err", 32'(b0.resp_err), 32'd0);
    tick();

    // Out-of-range read, then sticky set/clear collision
    cmd0(1'b0, 4'd7, 2'd0, 32'h0);
    tick();
    b0.cmd_valid = 1'b0;
    chk("oor_no_strobe", 32'(b0.bank_write), 32'd0);
    chk("oor_sticky_pre", 32'(sticky0), 32'd0);
    tick();
    chk("oor_resp_valid", 32'(b0.resp_valid), 32'd1);
    chk("oor_resp_err", 32'(b0.resp_err), 32'd1);
    chk("oor_resp_data", b0.resp_data, 32'd0);
    chk("oor_sticky", 32'(sticky0), 32'd1);
    tick();
    cmd0(1'b1, 4'd9, 2'd3, 32'h5A5A5A5A);
    tick();
    b0.cmd_valid = 1'b0;
    chk("oor_wr_no_strobe", 32'(b0.bank_write), 32'd0);
    err_clear0 = 1'b1;
    tick();
    err_clear0 = 1'b0;
    chk("oor_set_wins", 32'(sticky0), 32'd1);
    chk("oor_wr_resp_err", 32'(b0.resp_err), 32'd1);
    tick();
    err_clear0 = 1'b1;
    tick();
    err_clear0 = 1'b0;
    chk("sticky_cleared", 32'(sticky0), 32'd0);

    // Back-to-back with cmd_valid held high
    cmd0(1'b1, 4'd0, 2'd0, 32'h00000001);
    chk("b2b_ready0", 32'(b0.cmd_ready), 32'd1);
    tick();
    chk("b2b_strobe_a", 32'(b0.bank_write), 32'h1);
    chk("b2b_ready1", 32'(b0.cmd_ready), 32'd0);
    cmd0(1'b1, 4'd1, 2'd1, 32'h00000002);
    tick();
    chk("b2b_resp_a", 32'(b0.resp_valid), 32'd1);
    chk("b2b_no_capture", b0.bank_wdata, 32'h00000001);
    chk("b2b_ready2", 32'(b0.cmd_ready), 32'd0);
    tick();
    chk("b2b_ready3", 32'(b0.cmd_ready), 32'd1);
    chk("b2b_idle_strobe", 32'(b0.bank_write), 32'd0);
    tick();
    chk("b2b_strobe_b", 32'(b0.bank_write), 32'h2);
    chk("b2b_wdata_b", b0.bank_wdata, 32'h00000002);
    cmd0(1'b0, 4'd2, 2'd2, 32'h0);
    tick();
    chk("b2b_resp_b", 32'(b0.resp_valid), 32'd1);
    tick();
    chk("b2b_ready6", 32'(b0.cmd_ready), 32'd1);
    tick();
    b0.cmd_valid = 1'b0;
    chk("b2b_read_no_strobe", 32'(b0.bank_write), 32'd0);
    chk("b2b_ready7", 32'(b0.cmd_ready), 32'd0);
    tick();
    chk("b2b_resp_c", b0.resp_data, 32'hAAAA0002);
    tick();
    chk("b2b_done_ready", 32'(b0.cmd_ready), 32'd1);
    tick();
    chk("b2b_no_fourth", 32'(b0.bank_write), 32'd0);
    chk("b2b_no_fourth_resp", 32'(b0.resp_valid), 32'd0);

    // Reset during ISSUE of a write, asserted before the next clock edge
    cmd0(1'b1, 4'd1, 2'd3, 32'h55AA55AA);
    tick();
    b0.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobe", 32'(b0.bank_write), 32'd0);
    chk("mid_rst_wdata", b0.bank_wdata, 32'd0);
    chk("mid_rst_addr", 32'(b0.bank_addr), 32'd0);
    chk("mid_rst_ready", 32'(b0.cmd_ready), 32'd1);
    tick();
    chk("mid_rst_resp1", 32'(b0.resp_valid), 32'd0);
    tick();
    chk("mid_rst_resp2", 32'(b0.resp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(b0.cmd_ready), 32'd1);
    chk("post_rst_strobe", 32'(b0.bank_write), 32'd0);
    chk("post_rst_resp", 32'(b0.resp_valid), 32'd0);
    chk("post_rst_resp_data", b0.resp_data, 32'd0);

    // Three-stage synchroniser
    rr_in0 = 1'b1;
    tick();
    chk("sync_edge1", 32'(rr_out0), 32'd0);
    tick();
    chk("sync_edge2", 32'(rr_out0), 32'd0);
    tick();
    chk("sync_edge3", 32'(rr_out0), 32'd1);
    rr_in0 = 1'b0;
    tick(); tick();
    chk("sync_fall2", 32'(rr_out0), 32'd1);
    tick();
    chk("sync_fall3", 32'(rr_out0), 32'd0);

    // Single-bank build
    cmd1(1'b1, 4'd0, 32'hCAFEF00D);
    tick();
    b1.cmd_valid = 1'b0;
    chk("nb1_wr_strobe", 32'(b1.bank_write), 32'd1);
    chk("nb1_wr_wdata", b1.bank_wdata, 32'hCAFEF00D);
    tick();
    chk("nb1_wr_err", 32'(b1.resp_err), 32'd0);
    tick();
    cmd1(1'b0, 4'd0, 32'h0);
    tick();
    b1.cmd_valid = 1'b0;
    tick();
    chk("nb1_rd_data", b1.resp_data, 32'h0BADF00D);
    chk("nb1_rd_valid", 32'(b1.resp_valid), 32'd1);
    tick();
    cmd1(1'b1, 4'd1, 32'h77777777);
    tick();
    b1.cmd_valid = 1'b0;
    chk("nb1_oor_no_strobe", 32'(b1.bank_write), 32'd0);
    tick();
    chk("nb1_oor_err", 32'(b1.resp_err), 32'd1);
    chk("nb1_oor_data", b1.resp_data, 32'd0);
    chk("nb1_oor_sticky", 32'(sticky1), 32'd1);
    chk("nb1_rr_idle", 32'(rr_out1), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pfc_bank_router.md
PFC_BANK_ROUTER -- requirements
Module: pfc_bank_router

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of PFC banks served (legal 1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, reset-request synchroniser depth (legal 2..4).
REQ-003 SHALL have input clock_core_sig, 1 bit: the clock; all flops rising-edge.
REQ-004 SHALL have input qsys_reset_n_sig, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have input cmd_valid, 1 bit: command request.
REQ-006 SHALL have output cmd_ready, 1 bit: command accept.
REQ-007 SHALL have input cmd_write, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have input cmd_bank, 4 bits: target bank index.
REQ-009 SHALL have input cmd_addr, 2 bits: register address within the bank.
REQ-010 SHALL have input cmd_wdata, 32 bits: write data.
REQ-011 SHALL have output resp_valid, 1 bit: one-cycle response strobe.
REQ-012 SHALL have output resp_data, 32 bits: read data.
REQ-013 SHALL have output resp_err, 1 bit: bank out of range, qualified by resp_valid.
REQ-014 SHALL have output bank_write, NUM_BANKS bits: one-hot write strobes.
REQ-015 SHALL have output bank_addr, 2 bits: shared register address.
REQ-016 SHALL have output bank_wdata, 32 bits: shared write data.
REQ-017 SHALL have input bank_rdata, NUM_BANKS*32 bits: bank k readdata at bits [32k+31:32k].
REQ-018 SHALL have output err_sticky, 1 bit: latched out-of-range flag.
REQ-019 SHALL have input err_clear, 1 bit: clears err_sticky.
REQ-020 SHALL have input resetreq_in, 1 bit: asynchronous CPU reset request.
REQ-021 SHALL have output resetreq_out, 1 bit: resetreq_in synchronised to clock_core_sig.

Function
REQ-022 SHALL implement the state machine IDLE -> ISSUE -> RESP -> IDLE, one state per cycle, with no other transitions.
REQ-023 SHALL drive cmd_ready to 1 only in IDLE.
REQ-024 SHALL accept a command, capturing write/bank/addr/wdata, when cmd_valid=1 and cmd_ready=1 at a clock edge, and SHALL then enter ISSUE.
REQ-025 SHALL drive bank_addr and bank_wdata from the captured registers, held stable until the next accept.
REQ-026 SHALL, in ISSUE for a write with bank < NUM_BANKS, assert bank_write[bank] for exactly that cycle; all other bits of bank_write SHALL be 0.
REQ-027 SHALL, in ISSUE for a read with bank < NUM_BANKS, register the bank's bank_rdata slice into resp_data at the ISSUE->RESP edge.
REQ-028 SHALL assert resp_valid for exactly the RESP cycle, giving an accept-edge-to-resp_valid latency of 2 cycles and a throughput of 1 command per 3 cycles.
REQ-029 SHALL set resp_data to 0 for writes and for out-of-range accesses.
REQ-030 SHALL, when bank >= NUM_BANKS, assert no bank_write bit, set resp_err=1 in RESP, and set err_sticky at the ISSUE->RESP edge.
REQ-031 SHALL clear err_sticky on err_clear=1; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-032 SHALL ignore cmd_valid outside IDLE: no capture, and no queueing of the command.
REQ-033 SHALL produce resetreq_out through a SYNC_STAGES flop chain, with latency of SYNC_STAGES edges after resetreq_in rises.
REQ-034 SHALL compute the bank index width as the ceiling of log2 of NUM_BANKS, minimum 1; cmd_bank bits above that width SHALL be used only for the range check.

Reset
REQ-035 SHALL, while reset is asserted, force state to IDLE and drive cmd_ready=1, with no accept occurring.
REQ-036 SHALL reset resp_valid, resp_err, resp_data, bank_write, bank_addr, bank_wdata, err_sticky, resetreq_out and all captured registers to 0.
REQ-037 SHALL, on reset asserted mid-operation, abort ISSUE/RESP immediately, and SHALL never produce the pending response or write strobe.

Structure
REQ-038 SHALL place the state encoding, DATA_W=32, ADDR_W=2 and the bank-index-width function in the shared package pfc_router_pkg.
REQ-039 SHALL implement the synchroniser as the sub-module pfc_reset_sync, parameterised by SYNC_STAGES.

Verification
REQ-040 SHALL verify the write path: NUM_BANKS=4, write bank 2 addr 1 data 0xDEADBEEF -> bank_write=0100 for 1 cycle at accept+1, bank_wdata=0xDEADBEEF, resp_valid at accept+2 with resp_data=0, resp_err=0.
REQ-041 SHALL verify the read path: bank3 rdata=0x12345678, read bank 3 -> resp_data=0x12345678 at accept+2, bank_write stays 0.
REQ-042 SHALL verify out of range: NUM_BANKS=4, read bank 7 -> no strobe, resp_err=1, resp_data=0, err_sticky=1; err_clear pulsed in the same cycle as a second bad access -> err_sticky remains 1.
REQ-043 SHALL verify back-to-back commands: cmd_valid held high with 3 commands -> accepts exactly 3 cycles apart, cmd_ready=0 in ISSUE/RESP.
REQ-044 SHALL verify reset mid-operation: reset asserted during ISSUE of a write -> strobe and resp_valid never seen, all outputs 0, cmd_ready=1 after release.
REQ-045 SHALL verify the synchroniser: SYNC_STAGES=3, resetreq_in rising -> resetreq_out high after 3 edges; NUM_BANKS=1 build -> bank 0 works, bank 1 flags resp_err.
